// File: rtl/tweet_store.sv
// Message store between the serial receiver and transmitter: appends received
// characters, honours a backspace code, and replays the buffer over valid/ready.
module tweet_store #(
    parameter int          DATA_W  = 8,
    parameter int          DEPTH   = 160,
    parameter int unsigned BS_CODE = 32'h08,
    parameter int          ECHO    = 0,
    localparam int         CW      = $clog2(DEPTH + 1)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              play,
    input  logic              clear,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              busy,
    output logic              overflow,
    output logic              play_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] BS_S = BS_CODE[DATA_W-1:0];
    localparam bit ECHO_EN = (ECHO != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     idx_r;
    logic [AW-1:0]     clr_addr_r;
    logic [DATA_W-1:0] tx_data_r;
    logic              tx_valid_r;
    logic              tx_src_r;
    logic              clr_req_r;
    logic              overflow_r;
    logic              play_done_r;

    logic              is_bs_s;
    logic              hs_s;
    logic              echo_free_s;
    logic              rx_ok_s;
    logic              store_s;
    logic              drop_s;
    logic              del_s;
    logic              last_s;
    logic              clr_go_s;
    logic [CW-1:0]     count_nxt_s;

    // Decode receive actions, handshakes and the post-receive count.
    always_comb begin
        is_bs_s     = (rx_data == BS_S);
        hs_s        = tx_valid_r && tx_ready;
        echo_free_s = !tx_valid_r || tx_ready;
        rx_ok_s     = (state_r == ST_IDLE) && !clear && rx_valid;
        store_s     = rx_ok_s && !is_bs_s && (count_r != CW'(DEPTH));
        drop_s      = rx_ok_s && !is_bs_s && (count_r == CW'(DEPTH));
        del_s       = rx_ok_s && is_bs_s && (count_r != {CW{1'b0}});
        last_s      = (idx_r == count_r - CW'(1));
        clr_go_s    = (clear || clr_req_r) && (!tx_valid_r || tx_ready);
        if (store_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (del_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Character memory: swept to zero in CLEAR, appended on store.
    always_ff @(posedge sysclk) begin
        if (state_r == ST_CLEAR) begin
            mem[clr_addr_r] <= {DATA_W{1'b0}};
        end else if (store_s) begin
            mem[count_r[AW-1:0]] <= rx_data;
        end
    end

    // Control FSM, count, flags and transmit register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            count_r     <= {CW{1'b0}};
            idx_r       <= {CW{1'b0}};
            clr_addr_r  <= {AW{1'b0}};
            tx_data_r   <= {DATA_W{1'b0}};
            tx_valid_r  <= 1'b0;
            tx_src_r    <= 1'b0;
            clr_req_r   <= 1'b0;
            overflow_r  <= 1'b0;
            play_done_r <= 1'b0;
        end else begin
            play_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clear) begin
                        state_r    <= ST_CLEAR;
                        count_r    <= {CW{1'b0}};
                        clr_addr_r <= {AW{1'b0}};
                    end else begin
                        count_r <= count_nxt_s;
                        if (drop_s) overflow_r <= 1'b1;
                        if (play) begin
                            if (count_nxt_s == {CW{1'b0}}) begin
                                play_done_r <= 1'b1;
                            end else begin
                                state_r   <= ST_PLAY;
                                idx_r     <= {CW{1'b0}};
                                clr_req_r <= 1'b0;
                            end
                        end
                    end
                    // A new echo is only taken when the previous one has gone.
                    if (ECHO_EN && (store_s || del_s) && echo_free_s) begin
                        tx_data_r  <= rx_data;
                        tx_valid_r <= 1'b1;
                        tx_src_r   <= 1'b0;
                    end else if (hs_s) begin
                        tx_valid_r <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (rx_valid) overflow_r <= 1'b1;
                    if (clr_go_s) begin
                        state_r    <= ST_CLEAR;
                        count_r    <= {CW{1'b0}};
                        clr_addr_r <= {AW{1'b0}};
                        tx_valid_r <= 1'b0;
                        clr_req_r  <= 1'b0;
                    end else begin
                        if (clear) clr_req_r <= 1'b1;
                        // A leftover echo drains without advancing the replay index.
                        if (hs_s) begin
                            tx_valid_r <= 1'b0;
                            if (tx_src_r) begin
                                if (last_s) begin
                                    play_done_r <= 1'b1;
                                    state_r     <= ST_IDLE;
                                end else begin
                                    idx_r <= idx_r + CW'(1);
                                end
                            end
                        end else if (!tx_valid_r) begin
                            tx_data_r  <= mem[idx_r[AW-1:0]];
                            tx_valid_r <= 1'b1;
                            tx_src_r   <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (rx_valid) overflow_r <= 1'b1;
                    if (hs_s) tx_valid_r <= 1'b0;
                    if (clr_addr_r == AW'(DEPTH - 1)) begin
                        state_r    <= ST_IDLE;
                        overflow_r <= 1'b0;
                    end else begin
                        clr_addr_r <= clr_addr_r + AW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign count     = count_r;
    assign full      = (count_r == CW'(DEPTH));
    assign busy      = (state_r != ST_IDLE);
    assign overflow  = overflow_r;
    assign play_done = play_done_r;

endmodule

// File: tb/tb_tweet_store.sv
// Self-checking bench for tweet_store: directed cases plus randomized
// store/backspace/replay rounds against a queue-based reference.
module tb_tweet_store;
    localparam int DP = 4;

    logic       sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic       reset, rx_valid, play, clear, tx_ready;
    logic [7:0] rx_data, tx_data;
    logic       tx_valid, full, busy, overflow, play_done;
    logic [2:0] count;

    logic       e_reset, e_rx_valid, e_play, e_clear, e_tx_ready;
    logic [7:0] e_rx_data, e_tx_data;
    logic       e_tx_valid, e_full, e_busy, e_overflow, e_play_done;
    logic [2:0] e_count;

    tweet_store #(.DATA_W(8), .DEPTH(DP), .BS_CODE(32'h08), .ECHO(0)) u_dut (
        .sysclk(sysclk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .play(play), .clear(clear), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .count(count), .full(full), .busy(busy),
        .overflow(overflow), .play_done(play_done)
    );

    tweet_store #(.DATA_W(8), .DEPTH(DP), .BS_CODE(32'h08), .ECHO(1)) u_echo (
        .sysclk(sysclk), .reset(e_reset), .rx_data(e_rx_data), .rx_valid(e_rx_valid),
        .play(e_play), .clear(e_clear), .tx_data(e_tx_data), .tx_valid(e_tx_valid),
        .tx_ready(e_tx_ready), .count(e_count), .full(e_full), .busy(e_busy),
        .overflow(e_overflow), .play_done(e_play_done)
    );

    int         checks = 0;
    int         failures = 0;
    int         pd;
    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic       m_ovf;

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; rx_valid = 1'b0; play = 1'b0; clear = 1'b0; tx_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    // Reference: queue of stored characters, backspace pops, full drops and flags.
    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        if (b == 8'h08) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end else if (mq.size() < DP) begin
            mq.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic collect(input bit rnd);
        got.delete();
        pd = 0;
        for (int c = 0; c < 60; c++) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (play_done) pd++;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            tick;
        end
        tx_ready = 1'b1;
    endtask

    task automatic run_play(input bit rnd);
        play = 1'b1;
        tick;
        play = 1'b0;
        collect(rnd);
    endtask

    task automatic check_replay(input string tag);
        check({tag, "_len"}, got.size(), mq.size());
        for (int i = 0; i < mq.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_byte%0d", tag, i), got[i], mq[i]);
        end
        check({tag, "_play_done_pulses"}, pd, 1);
        check({tag, "_count"}, count, mq.size());
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int         k;
        int         n;
        logic       sawv;
        logic [7:0] b;

        rx_data = 8'h00; e_rx_data = 8'h00;
        e_reset = 1'b1; e_rx_valid = 1'b0; e_play = 1'b0; e_clear = 1'b0; e_tx_ready = 1'b1;
        do_reset;
        e_reset = 1'b0;

        check("rst_count", count, 3'd0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_play_done", play_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);

        // Basic store and replay
        send(8'h41); send(8'h42); send(8'h43);
        check("t1_no_echo", tx_valid, 1'b0);
        run_play(1'b0);
        check_replay("t1");

        // Backspace, including at empty
        do_reset;
        send(8'h08);
        check("t2_bs_empty_count", count, 3'd0);
        check("t2_bs_empty_ovf", overflow, 1'b0);
        send(8'h41); send(8'h42); send(8'h08); send(8'h43);
        run_play(1'b0);
        check_replay("t2");

        // Overflow then backspace
        do_reset;
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        check("t3_count", count, 3'd4);
        check("t3_full", full, 1'b1);
        check("t3_ovf", overflow, 1'b1);
        send(8'h08);
        check("t3_bs_count", count, 3'd3);
        check("t3_bs_full", full, 1'b0);
        check("t3_bs_ovf", overflow, 1'b1);

        // rx and play in the same cycle: the new byte is replayed too
        do_reset;
        send(8'h59);
        rx_data = 8'h5a; rx_valid = 1'b1; play = 1'b1;
        tick;
        rx_valid = 1'b0; play = 1'b0;
        mq.push_back(8'h5a);
        collect(1'b0);
        check_replay("rxplay");

        // Backpressure holds data; next byte follows quickly
        do_reset;
        send(8'h41); send(8'h42); send(8'h43);
        tx_ready = 1'b0;
        play = 1'b1; tick; play = 1'b0;
        tick;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", tx_valid, 1'b1);
            check("t4_hold_data", tx_data, 8'h41);
            tick;
        end
        tx_ready = 1'b1;
        tick;
        k = 0;
        while (!tx_valid && k < 5) begin
            tick;
            k++;
        end
        check("t4_next_within_2", (k >= 1 && k <= 2), 1'b1);
        check("t4_next_data", tx_data, 8'h42);
        collect(1'b0);
        check("t4_rest_len", got.size(), 2);
        for (int i = 0; i < got.size() && i < 2; i++) check("t4_rest_byte", got[i], mq[i+1]);
        check("t4_pd", pd, 1);

        // Clear during replay
        do_reset;
        for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
        check("t5_pre_ovf", overflow, 1'b1);
        play = 1'b1; tick; play = 1'b0;
        tick;
        check("t5_first_data", tx_data, 8'h31);
        clear = 1'b1; tick; clear = 1'b0;
        check("t5_clear_busy", busy, 1'b1);
        check("t5_clear_count", count, 3'd0);
        n = 0; sawv = 1'b0;
        while (busy && n < 100) begin
            if (tx_valid) sawv = 1'b1;
            n++;
            tick;
        end
        check("t5_busy_cycles", n, DP);
        check("t5_no_tx_in_clear", sawv, 1'b0);
        check("t5_post_count", count, 3'd0);
        check("t5_post_ovf", overflow, 1'b0);
        play = 1'b1; tick; play = 1'b0;
        check("t5_empty_play_done", play_done, 1'b1);
        check("t5_empty_tx_valid", tx_valid, 1'b0);
        check("t5_empty_busy", busy, 1'b0);
        tick;
        check("t5_play_done_once", play_done, 1'b0);

        // Echo mode
        e_tx_ready = 1'b0;
        e_rx_data = 8'h78; e_rx_valid = 1'b1; tick; e_rx_valid = 1'b0;
        check("t6_echo_valid", e_tx_valid, 1'b1);
        check("t6_echo_data", e_tx_data, 8'h78);
        e_rx_data = 8'h79; e_rx_valid = 1'b1; tick; e_rx_valid = 1'b0;
        check("t6_echo_discard_data", e_tx_data, 8'h78);
        check("t6_echo_discard_count", e_count, 3'd2);
        e_tx_ready = 1'b1; tick;
        check("t6_echo_done", e_tx_valid, 1'b0);
        e_rx_data = 8'h08; e_rx_valid = 1'b1; tick; e_rx_valid = 1'b0;
        check("t6_echo_bs_data", e_tx_data, 8'h08);
        check("t6_echo_bs_count", e_count, 3'd1);
        tick;
        e_play = 1'b1; tick; e_play = 1'b0;
        tick;
        check("t6_play_valid", e_tx_valid, 1'b1);
        check("t6_play_data", e_tx_data, 8'h78);
        e_reset = 1'b1; tick; e_reset = 1'b0;
        check("t6_rst_tx_valid", e_tx_valid, 1'b0);
        check("t6_rst_count", e_count, 3'd0);
        check("t6_rst_busy", e_busy, 1'b0);

        // Randomized rounds with random transmitter backpressure
        for (int r = 0; r < 10; r++) begin
            do_reset;
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'h08 : 8'($urandom_range(32, 126));
                send(b);
            end
            check("rnd_count", count, mq.size());
            check("rnd_ovf", overflow, m_ovf);
            check("rnd_full", full, (mq.size() == DP));
            run_play(1'b1);
            check_replay("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
